// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the instruction/data memory arbiter
package riscv_mem_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: 0-based busy-cycle counter that flags when a memory transaction has waited TIMEOUT cycles
module mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
    assign expired = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: serializes fetch and data requests onto one variable-latency memory,
// data first, with pipeline stall generation and an ack watchdog.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter logic [XLEN-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            err
);
    arb_state_t state, state_nx;
    logic we_q, expired, done, i_take, d_take;
    logic [XLEN-1:0] rd_val;
    // a port in its ready cycle is masked so its still-held request is not reissued
    assign i_take = i_req & ~i_ready;
    assign d_take = d_req & ~d_ready;
    assign stall = i_take | d_take;
    assign mem_req = state != IDLE;
    assign mem_we = we_q & mem_req;
    assign done = mem_ack | expired;
    assign rd_val = mem_ack ? mem_rdata : ERR_DATA;

    mem_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_watchdog (
        .clk(clk),
        .reset(reset),
        .clear(state == IDLE),
        .en(mem_req),
        .expired(expired)
    );

    always_comb begin
        state_nx = state == IDLE ? (d_take ? BUSY_D : i_take ? BUSY_I : IDLE)
                 : done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            mem_wdata <= '0;
            we_q <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err <= 1'b0;
        end else begin
            i_ready <= state == BUSY_I && done;
            d_ready <= state == BUSY_D && done;
            if (state == IDLE && d_take) begin
                mem_addr <= d_addr;
                mem_wdata <= d_wdata;
                we_q <= d_we;
            end else if (state == IDLE && i_take) begin
                mem_addr <= i_addr;
                we_q <= 1'b0;
            end
            if (state == BUSY_I && done) i_rdata <= rd_val;
            if (state == BUSY_D && done && !we_q) d_rdata <= rd_val;
            // an ack landing in the timeout cycle wins, so no error then
            if (expired && !mem_ack) err <= 1'b1;
        end
    end
endmodule
